// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: latches a pattern/length configuration,
// then hunts a 1-bit stream for it, counting matches until an optional target.
module seq_det_ctrl #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_cnt,
    input  logic             cfg_ovl,
    input  logic             start,
    input  logic             stop,
    input  logic             din,
    input  logic             din_vld,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {IDLE, FILL, HUNT, DONE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-1:0] sr_q, sr_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             match_q, match_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] sr_shift;
    logic [LEN_W-1:0] fill_inc;
    logic [CNT_W-1:0] mcnt_inc;
    logic             len_ok;
    logic             hit;

    // The match test looks at the window that already contains the incoming bit.
    always_comb begin
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len_q));
        end
        len_ok   = (len_q != '0) && (len_q <= LEN_W'(PAT_W));
        sr_shift = {sr_q[PAT_W-2:0], din};
        fill_inc = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
        mcnt_inc = (mcnt_q == '1) ? mcnt_q : mcnt_q + CNT_W'(1);
        hit      = (fill_inc >= len_q) && ((sr_shift & mask) == (pat_q & mask));
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ovl_d   = ovl_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        mcnt_d  = mcnt_q;
        err_d   = err_q;
        match_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pat_d = cfg_pat;
                    len_d = cfg_len;
                    cnt_d = cfg_cnt;
                    ovl_d = cfg_ovl;
                    err_d = 1'b0;
                end
                if (start) begin
                    if (len_ok) begin
                        state_d = FILL;
                        mcnt_d  = '0;
                        sr_d    = '0;
                        fill_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL, HUNT: begin
                if (cfg_we) begin
                    err_d = 1'b1;
                end
                if (stop) begin
                    state_d = IDLE;
                end else if (din_vld) begin
                    sr_d    = sr_shift;
                    fill_d  = fill_inc;
                    state_d = (fill_inc >= len_q) ? HUNT : FILL;
                    if (hit) begin
                        match_d = 1'b1;
                        mcnt_d  = mcnt_inc;
                        if ((cnt_q != '0) && (mcnt_inc == cnt_q)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (!ovl_q) begin
                            state_d = FILL;
                            fill_d  = '0;
                        end
                    end
                end
            end
            DONE: begin
                if (cfg_we) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FILL) || (state_d == HUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= LEN_W'(1);
            cnt_q   <= '0;
            ovl_q   <= 1'b0;
            sr_q    <= '0;
            fill_q  <= '0;
            mcnt_q  <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ovl_q   <= ovl_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            mcnt_q  <= mcnt_d;
            match_q <= match_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = mcnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = err_q;

endmodule
